elevator_dispatcher: RTL and testbench

- Command-side counterpart of the elevator car controller.
- Accepts floor calls (floors 0..3), queues them in a small FIFO, and drives the car's 2-bit move command (x1,x0) one floor step at a time.
- Closes the loop on the car's reported floor (z1,z0) and supervises each step with a timeout.
- Sits between the call-button logic and the elevator module in the top level.

---
 rtl/elevator_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_elevator_dispatcher.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/elevator_dispatcher.sv
// Floor-call dispatcher: queues calls and steps the car one floor at a time, with a per-step timeout.
// Optional auto-park to floor 0 after an idle period is enabled by defining ELEVATOR_PARK_EN.
module elevator_dispatcher #(
    parameter int DEPTH        = 4,
    parameter int MOVE_TIMEOUT = 8,
    parameter int PARK_DELAY   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       call_valid,
    input  logic [1:0] call_floor,
    output logic       call_ready,
    input  logic       z1,
    input  logic       z0,
    output logic       x1,
    output logic       x0,
    output logic       arrived,
    output logic       busy,
    output logic       fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] TO_LAST = 8'(MOVE_TIMEOUT - 1);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        MOVE_TIMEOUT < 2 || MOVE_TIMEOUT > 255 ||
        PARK_DELAY < 1 || PARK_DELAY > 255) begin : g_bad_param
        $error("elevator_dispatcher: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ARRIVE,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic [1:0]      exp_q, exp_d;
    logic [7:0]      timer_q, timer_d;
    logic            x1_q, x1_d, x0_q, x0_d;
    logic            arrived_q, arrived_d, busy_q, busy_d, fault_q, fault_d;

    logic [1:0]      cur, head, push_floor;
    logic            ext_push, park_push, push, pop;

`ifdef ELEVATOR_PARK_EN
    localparam logic [7:0] PARK_LAST = 8'(PARK_DELAY - 1);
    logic [7:0] park_cnt_q, park_cnt_d;
`endif

    assign call_ready = !full_q && !fault_q;

    always_comb begin
        cur        = {z1, z0};
        head       = fifo_q[rd_ptr_q];
        ext_push   = call_valid && call_ready;
        park_push  = 1'b0;
`ifdef ELEVATOR_PARK_EN
        park_cnt_d = 8'd0;
        // An external call in the trigger cycle wins and restarts the idle count.
        if (state_q == S_IDLE && count_q == '0 && cur != 2'd0 && !ext_push) begin
            if (park_cnt_q == PARK_LAST) begin
                park_push = 1'b1;
            end else begin
                park_cnt_d = park_cnt_q + 8'd1;
            end
        end
`endif
        push       = ext_push || park_push;
        push_floor = ext_push ? call_floor : 2'd0;
        pop        = (state_q == S_ARRIVE);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(DEPTH));

        state_d   = state_q;
        exp_d     = exp_q;
        timer_d   = timer_q;
        x1_d      = 1'b0;
        x0_d      = 1'b0;
        arrived_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (head == cur) begin
                    state_d = S_ARRIVE;
                end else begin
                    x0_d    = 1'b1;
                    x1_d    = (head > cur);
                    exp_d   = (head > cur) ? cur + 2'd1 : cur - 2'd1;
                    timer_d = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (cur == exp_q) begin
                    state_d = S_ISSUE;
                end else if (timer_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_ARRIVE: begin
                arrived_d = 1'b1;
                state_d   = (count_d != '0) ? S_ISSUE : S_IDLE;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            exp_q      <= 2'd0;
            timer_q    <= 8'd0;
            x1_q       <= 1'b0;
            x0_q       <= 1'b0;
            arrived_q  <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
`ifdef ELEVATOR_PARK_EN
            park_cnt_q <= 8'd0;
`endif
        end else begin
            if (push) fifo_q[wr_ptr_q] <= push_floor;
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            exp_q      <= exp_d;
            timer_q    <= timer_d;
            x1_q       <= x1_d;
            x0_q       <= x0_d;
            arrived_q  <= arrived_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
`ifdef ELEVATOR_PARK_EN
            park_cnt_q <= park_cnt_d;
`endif
        end
    end

    assign x1      = x1_q;
    assign x0      = x0_q;
    assign arrived = arrived_q;
    assign busy    = busy_q;
    assign fault   = fault_q;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed vector bench for elevator_dispatcher; expected outputs packed as
// {x1,x0,arrived,busy,fault,call_ready}, observed during the cycle each row is applied.
module tb_elevator_dispatcher;
    logic       clk = 1'b0;
    logic       reset, call_valid, call_ready, z1, z0, x1, x0, arrived, busy, fault;
    logic [1:0] call_floor;

    elevator_dispatcher #(.DEPTH(4), .MOVE_TIMEOUT(8), .PARK_DELAY(4)) dut (
        .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
        .call_ready(call_ready), .z1(z1), .z0(z0), .x1(x1), .x0(x0),
        .arrived(arrived), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       cv;
        logic [1:0] cf;
        logic [1:0] z;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] IDL  = 6'b000001;
    localparam logic [5:0] BSY  = 6'b000101;
    localparam logic [5:0] UP   = 6'b110101;
    localparam logic [5:0] DN   = 6'b010101;
    localparam logic [5:0] ARI  = 6'b001001;
    localparam logic [5:0] ARB  = 6'b001101;
    localparam logic [5:0] BFL  = 6'b000100;
    localparam logic [5:0] FLT  = 6'b000110;
`ifdef ELEVATOR_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input string n, input logic r, input logic cv, input logic [1:0] cf,
                       input logic [1:0] z, input logic [5:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.cv = cv; v.cf = cf; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        logic [5:0] act;
        reset = v.rst; call_valid = v.cv; call_floor = v.cf; {z1, z0} = v.z;
        #1;
        act = {x1, x0, arrived, busy, fault, call_ready};
        n_vec++;
        if (act !== v.exp) begin
            n_miss++;
            $display("FAIL %s: got x1x0/arr/busy/fault/rdy=%b, want %b", v.name, act, v.exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic seq(input string n, input logic r, input logic cv, input logic [1:0] cf,
                       input logic [1:0] z, input logic [5:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.cv = cv; v.cf = cf; v.z = z; v.exp = e;
        apply(v);
    endtask

    initial begin
        reset = 1'b1; call_valid = 1'b0; call_floor = 2'd0; {z1, z0} = 2'd0;
        repeat (2) @(posedge clk);
        #1;

        add("reset_state", 0, 0, 0, 0, IDL);
        // 0 -> 2: two up steps then arrival
        add("t1_c0", 0, 1, 2, 0, IDL);  add("t1_c1", 0, 0, 0, 0, IDL);
        add("t1_c2", 0, 0, 0, 0, BSY);  add("t1_c3_up", 0, 0, 0, 0, UP);
        add("t1_c4", 0, 0, 0, 1, BSY);  add("t1_c5", 0, 0, 0, 1, BSY);
        add("t1_c6_up", 0, 0, 0, 1, UP); add("t1_c7", 0, 0, 0, 2, BSY);
        add("t1_c8", 0, 0, 0, 2, BSY);  add("t1_c9", 0, 0, 0, 2, BSY);
        add("t1_arr", 0, 0, 0, 2, ARI); add("t1_after", 0, 0, 0, 2, IDL);
        // at 3: calls 1 then 3
        add("t2_c0", 0, 1, 1, 3, IDL);  add("t2_c1", 0, 1, 3, 3, IDL);
        add("t2_c2", 0, 0, 0, 3, BSY);  add("t2_c3_dn", 0, 0, 0, 3, DN);
        add("t2_c4", 0, 0, 0, 2, BSY);  add("t2_c5", 0, 0, 0, 2, BSY);
        add("t2_c6_dn", 0, 0, 0, 2, DN); add("t2_c7", 0, 0, 0, 1, BSY);
        add("t2_c8", 0, 0, 0, 1, BSY);  add("t2_c9", 0, 0, 0, 1, BSY);
        add("t2_arr1", 0, 0, 0, 1, ARB); add("t2_c11_up", 0, 0, 0, 1, UP);
        add("t2_c12", 0, 0, 0, 2, BSY); add("t2_c13", 0, 0, 0, 2, BSY);
        add("t2_c14_up", 0, 0, 0, 2, UP); add("t2_c15", 0, 0, 0, 3, BSY);
        add("t2_c16", 0, 0, 0, 3, BSY); add("t2_c17", 0, 0, 0, 3, BSY);
        add("t2_arr2", 0, 0, 0, 3, ARI); add("t2_after", 0, 0, 0, 3, IDL);
        // call for the current floor
        add("t4_c0", 0, 1, 1, 1, IDL);  add("t4_c1", 0, 0, 0, 1, IDL);
        add("t4_issue", 0, 0, 0, 1, BSY); add("t4_arrive", 0, 0, 0, 1, BSY);
        add("t4_arr", 0, 0, 0, 1, ARI);
        // fill FIFO while the car stalls, then timeout
        add("t3_c0", 0, 1, 3, 0, IDL);  add("t3_c1", 0, 1, 2, 0, IDL);
        add("t3_c2", 0, 1, 1, 0, BSY);  add("t3_c3_up", 0, 1, 3, 0, UP);
        add("t3_full_drop", 0, 1, 2, 0, BFL);
        for (int i = 5; i <= 10; i++) add($sformatf("t3_wait%0d", i), 0, 0, 0, 0, BFL);
        add("t3_fault", 0, 0, 0, 0, FLT); add("t3_fault_sticky", 0, 1, 0, 0, FLT);
        // reset during WAIT of a 0 -> 3 trip
        add("t5_rst_from_fault", 1, 0, 0, 0, FLT);
        add("t5_c0", 0, 1, 3, 0, IDL);  add("t5_c1", 0, 0, 0, 0, IDL);
        add("t5_c2", 0, 0, 0, 0, BSY);  add("t5_c3_up", 0, 0, 0, 0, UP);
        add("t5_rst_wait", 1, 0, 0, 0, BSY);
        add("t5_post_rst", 0, 0, 0, 0, IDL);
        add("t5_empty1", 0, 0, 0, 0, IDL); add("t5_empty2", 0, 0, 0, 0, IDL);

        foreach (vecs[i]) apply(vecs[i]);

        // idle at floor 2: auto-park only when the feature is built in
        seq("pk_rst", 1, 0, 0, 0, IDL);
        for (int i = 0; i < 4; i++) seq($sformatf("pk_idle%0d", i), 0, 0, 0, 2, IDL);
        seq("pk_push", 0, 0, 0, 2, IDL);
        seq("pk_issue", 0, 0, 0, 2, PARK ? BSY : IDL);
        seq("pk_dn1", 0, 0, 0, 2, PARK ? DN : IDL);
        seq("pk_f1", 0, 0, 0, 1, PARK ? BSY : IDL);
        seq("pk_f1b", 0, 0, 0, 1, PARK ? BSY : IDL);
        seq("pk_dn2", 0, 0, 0, 1, PARK ? DN : IDL);
        seq("pk_f0", 0, 0, 0, 0, PARK ? BSY : IDL);
        seq("pk_f0b", 0, 0, 0, 0, PARK ? BSY : IDL);
        seq("pk_arrive", 0, 0, 0, 0, PARK ? BSY : IDL);
        seq("pk_arr", 0, 0, 0, 0, PARK ? ARI : IDL);
        seq("pk_after", 0, 0, 0, 0, IDL);

        // a call in the 4th idle cycle suppresses the park
        seq("sp_rst", 1, 0, 0, 0, IDL);
        for (int i = 0; i < 3; i++) seq($sformatf("sp_idle%0d", i), 0, 0, 0, 2, IDL);
        seq("sp_call", 0, 1, 3, 2, IDL);
        seq("sp_c4", 0, 0, 0, 2, IDL);
        seq("sp_issue", 0, 0, 0, 2, BSY);
        seq("sp_up", 0, 0, 0, 2, UP);
        seq("sp_f3", 0, 0, 0, 3, BSY);
        seq("sp_f3b", 0, 0, 0, 3, BSY);
        seq("sp_arrive", 0, 0, 0, 3, BSY);
        seq("sp_arr_only_one", 0, 0, 0, 3, ARI);
        seq("sp_after", 0, 0, 0, 3, IDL);
        seq("sp_end_rst", 1, 0, 0, 0, IDL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
